// File: rtl/clock_gate_controller.sv
// Multi-channel clock-enable controller: per-domain BUFGCE enables switched through a
// request/acknowledge handshake with a programmable drain before gating, a stretched
// domain reset sequenced from PLL lock, and a saturating enabled-cycle counter per channel.
module clock_gate_controller #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned RST_STRETCH  = 3,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                pll_locked,
  input  logic [NUM_CHANNELS-1:0]             start_req,
  input  logic [NUM_CHANNELS-1:0]             stop_req,
  input  logic [NUM_CHANNELS-1:0]             count_clear,
  output logic [NUM_CHANNELS-1:0]             clock_en,
  output logic [NUM_CHANNELS-1:0]             ack,
  output logic                                domain_rst,
  output logic                                lock_lost,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] enabled_cycles
);

  localparam int unsigned StretchW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
  localparam logic [StretchW-1:0] StretchLast = StretchW'(RST_STRETCH - 1);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLast =
      DrainW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    StStopped,
    StRunning,
    StDrain
  } chan_state_e;

  logic [StretchW-1:0] stretch_q, stretch_d;
  logic                domain_rst_q, domain_rst_d;
  logic                lock_lost_q, lock_lost_d;
  logic                lock_drop;

  // Lock dropping after the domains were released: every channel stops at once.
  assign lock_drop = ~pll_locked & ~domain_rst_q;

  // Reset sequencer next state: count consecutive locked cycles, reload on any unlock.
  always_comb begin
    stretch_d    = stretch_q;
    domain_rst_d = domain_rst_q;
    lock_lost_d  = lock_lost_q | lock_drop;
    if (!pll_locked) begin
      stretch_d    = '0;
      domain_rst_d = 1'b1;
    end else if (domain_rst_q) begin
      if (stretch_q == StretchLast) begin
        domain_rst_d = 1'b0;
      end else begin
        stretch_d = stretch_q + StretchW'(1);
      end
    end
  end

  // Reset sequencer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stretch_q    <= '0;
      domain_rst_q <= 1'b1;
      lock_lost_q  <= 1'b0;
    end else begin
      stretch_q    <= stretch_d;
      domain_rst_q <= domain_rst_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign domain_rst = domain_rst_q;
  assign lock_lost  = lock_lost_q;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    chan_state_e             state_q, state_d;
    logic [DrainW-1:0]       drain_q, drain_d;
    logic                    clock_en_q, clock_en_d;
    logic                    ack_q, ack_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;

    // Channel FSM next state, enable and completion pulse.
    always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
        StStopped: begin
          // start beats a simultaneous stop here since stop is not looked at
          if (start_req[i] && !domain_rst_q) state_d = StRunning;
        end
        StRunning: begin
          if (stop_req[i]) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = StStopped;
            end else begin
              state_d = StDrain;
              drain_d = '0;
            end
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            state_d = StStopped;
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
        default: state_d = StStopped;
      endcase
      if (lock_drop) state_d = StStopped;

      clock_en_d = (state_d != StStopped);
      // A forced stop from lock loss is not a completed handshake, so no ack.
      ack_d = ((state_q == StStopped) && (state_d == StRunning)) ||
              ((state_q != StStopped) && (state_d == StStopped) && !lock_drop);
    end

    // Enabled-cycle counter next state: clear wins, otherwise saturating increment.
    always_comb begin
      count_d = count_q;
      if (count_clear[i]) begin
        count_d = '0;
      end else if (clock_en_q && (count_q != '1)) begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end

    // Channel state, output and counter registers.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q    <= StStopped;
        drain_q    <= '0;
        clock_en_q <= 1'b0;
        ack_q      <= 1'b0;
        count_q    <= '0;
      end else begin
        state_q    <= state_d;
        drain_q    <= drain_d;
        clock_en_q <= clock_en_d;
        ack_q      <= ack_d;
        count_q    <= count_d;
      end
    end

    assign clock_en[i] = clock_en_q;
    assign ack[i]      = ack_q;
    assign enabled_cycles[i*COUNT_WIDTH +: COUNT_WIDTH] = count_q;
  end

endmodule

// File: tb/tb_clock_gate_controller.sv
// Scoreboard bench for clock_gate_controller: stimulus queues expected snapshots and ack
// events by cycle number; a negedge monitor pops and compares them as the DUT presents them.
module tb_clock_gate_controller;

  localparam int unsigned NC = 8;
  localparam int unsigned CW = 4;

  logic              clock;
  logic              reset;
  logic              pll_locked;
  logic [NC-1:0]     start_req;
  logic [NC-1:0]     stop_req;
  logic [NC-1:0]     count_clear;
  logic [NC-1:0]     clock_en;
  logic [NC-1:0]     ack;
  logic              domain_rst;
  logic              lock_lost;
  logic [NC*CW-1:0]  enabled_cycles;

  clock_gate_controller #(
    .NUM_CHANNELS(NC),
    .RST_STRETCH (3),
    .DRAIN_CYCLES(2),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .count_clear   (count_clear),
    .clock_en      (clock_en),
    .ack           (ack),
    .domain_rst    (domain_rst),
    .lock_lost     (lock_lost),
    .enabled_cycles(enabled_cycles)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          kind;  // 0: clock_en/domain_rst/lock_lost, 1: one counter
    int          ch;
    logic [NC-1:0] ce;
    logic        dr;
    logic        ll;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [NC-1:0] mask;
  } ack_t;

  exp_t sb[$];
  ack_t ackq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void push_exp(input exp_t e);
    int i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endfunction

  function automatic void exp_state(input int at, input string nm, input logic [NC-1:0] ce,
                                    input logic dr, input logic ll);
    exp_t e;
    e.cyc = at; e.name = nm; e.kind = 0; e.ch = 0;
    e.ce = ce; e.dr = dr; e.ll = ll; e.cnt = '0;
    push_exp(e);
  endfunction

  function automatic void exp_cnt(input int at, input string nm, input int ch,
                                  input logic [CW-1:0] v);
    exp_t e;
    e.cyc = at; e.name = nm; e.kind = 1; e.ch = ch;
    e.ce = '0; e.dr = 1'b0; e.ll = 1'b0; e.cnt = v;
    push_exp(e);
  endfunction

  function automatic void exp_ack(input int at, input logic [NC-1:0] m);
    ack_t a;
    int i = 0;
    a.cyc = at; a.mask = m;
    while (i < ackq.size() && ackq[i].cyc <= at) i++;
    ackq.insert(i, a);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  exp_t          mon_e;
  ack_t          mon_a;
  logic [CW-1:0] mon_got;

  // Monitor: compare every snapshot due this cycle, and every ack pulse the DUT shows.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d skipped at cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (mon_e.kind == 0) begin
        if (clock_en !== mon_e.ce || domain_rst !== mon_e.dr || lock_lost !== mon_e.ll) begin
          n_fail++;
          $display("FAIL %s @%0d: got ce=%h rst=%b lost=%b, want ce=%h rst=%b lost=%b",
                   mon_e.name, cyc, clock_en, domain_rst, lock_lost,
                   mon_e.ce, mon_e.dr, mon_e.ll);
        end
      end else begin
        mon_got = enabled_cycles[mon_e.ch*CW +: CW];
        if (mon_got !== mon_e.cnt) begin
          n_fail++;
          $display("FAIL %s @%0d: enabled_cycles[%0d] got %0d want %0d",
                   mon_e.name, cyc, mon_e.ch, mon_got, mon_e.cnt);
        end
      end
    end
    if (ack !== '0) begin
      n_vec++;
      if (ackq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack @%0d: got ack=%h want none", cyc, ack);
      end else begin
        mon_a = ackq.pop_front();
        if (mon_a.cyc != cyc || ack !== mon_a.mask) begin
          n_fail++;
          $display("FAIL ack @%0d: got ack=%h want ack=%h at cycle %0d",
                   cyc, ack, mon_a.mask, mon_a.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset       = 1'b1;
    pll_locked  = 1'b1;
    start_req   = '0;
    stop_req    = '0;
    count_clear = '0;
    step(1);

    // Reset held with lock present, then release: domain_rst falls 3 cycles later.
    repeat (5) begin
      exp_state(cyc, "reset_hold", 8'h00, 1'b1, 1'b0);
      exp_cnt(cyc, "reset_cnt", 0, 4'd0);
      step(1);
    end
    reset = 1'b0;
    t = cyc;
    exp_state(t,     "stretch0", 8'h00, 1'b1, 1'b0);
    exp_state(t + 1, "stretch1", 8'h00, 1'b1, 1'b0);
    exp_state(t + 2, "stretch2", 8'h00, 1'b1, 1'b0);
    exp_state(t + 3, "rst_release", 8'h00, 1'b0, 1'b0);
    exp_state(t + 4, "start_in_rst_ignored", 8'h00, 1'b0, 1'b0);
    step(1);
    start_req[0] = 1'b1;  // held while domain_rst is still high
    step(2);
    start_req[0] = 1'b0;
    step(1);

    // Channel 1: start, run, stop with a two-cycle drain.
    t = cyc;
    start_req[1] = 1'b1;
    exp_ack(t + 1, 8'h02);
    exp_state(t + 1, "ch1_start", 8'h02, 1'b0, 1'b0);
    exp_cnt(t + 2, "ch1_cnt_first", 1, 4'd1);
    exp_state(t + 13, "ch1_drain_end", 8'h02, 1'b0, 1'b0);
    exp_state(t + 14, "ch1_stopped", 8'h00, 1'b0, 1'b0);
    exp_ack(t + 14, 8'h02);
    exp_cnt(t + 14, "ch1_cnt13", 1, 4'd13);
    exp_cnt(t + 15, "ch1_cnt_hold", 1, 4'd13);
    step(1);
    start_req[1] = 1'b0;
    step(10);
    stop_req[1] = 1'b1;
    step(1);
    stop_req[1] = 1'b0;
    step(4);

    // Channel 2: start+stop while stopped starts, while running drains, start in drain ignored.
    t = cyc;
    start_req[2] = 1'b1;
    stop_req[2]  = 1'b1;
    exp_ack(t + 1, 8'h04);
    exp_state(t + 1, "both_stopped_starts", 8'h04, 1'b0, 1'b0);
    exp_state(t + 4, "both_running_drains", 8'h04, 1'b0, 1'b0);
    exp_state(t + 5, "drain_done", 8'h00, 1'b0, 1'b0);
    exp_ack(t + 5, 8'h04);
    exp_state(t + 6, "start_in_drain_ignored", 8'h00, 1'b0, 1'b0);
    exp_cnt(t + 6, "ch2_cnt4", 2, 4'd4);
    step(1);
    start_req[2] = 1'b0;
    stop_req[2]  = 1'b0;
    step(1);
    start_req[2] = 1'b1;
    stop_req[2]  = 1'b1;
    step(1);
    stop_req[2] = 1'b0;  // start_req alone during drain
    step(1);
    start_req[2] = 1'b0;
    step(3);

    // Channels 3..5 run; channel 3 saturates and is cleared; then lock drops for one cycle.
    t = cyc;
    start_req = 8'h38;
    exp_ack(t + 1, 8'h38);
    exp_state(t + 1, "three_run", 8'h38, 1'b0, 1'b0);
    exp_cnt(t + 10, "ch3_cnt9", 3, 4'd9);
    exp_cnt(t + 16, "ch3_sat", 3, 4'd15);
    exp_cnt(t + 22, "ch3_sat_hold", 3, 4'd15);
    exp_cnt(t + 23, "ch3_cleared", 3, 4'd0);
    exp_cnt(t + 24, "ch3_after_clear1", 3, 4'd1);
    exp_cnt(t + 25, "ch3_after_clear2", 3, 4'd2);
    exp_state(t + 26, "pre_lock_drop", 8'h38, 1'b0, 1'b0);
    exp_state(t + 27, "lock_drop", 8'h00, 1'b1, 1'b1);
    exp_cnt(t + 28, "ch3_cnt_frozen", 3, 4'd4);
    exp_state(t + 29, "relock_stretch", 8'h00, 1'b1, 1'b1);
    exp_state(t + 30, "relock_release", 8'h00, 1'b0, 1'b1);
    step(1);
    start_req = '0;
    step(21);
    count_clear[3] = 1'b1;
    step(1);
    count_clear[3] = 1'b0;
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(3);

    // All eight channels start together; only even channels stop.
    t = cyc;
    start_req = 8'hFF;
    exp_ack(t + 1, 8'hFF);
    exp_state(t + 1, "all_start", 8'hFF, 1'b0, 1'b1);
    exp_state(t + 5, "even_draining", 8'hFF, 1'b0, 1'b1);
    exp_ack(t + 6, 8'h55);
    exp_state(t + 6, "even_stopped", 8'hAA, 1'b0, 1'b1);
    exp_state(t + 7, "odd_still_run", 8'hAA, 1'b0, 1'b1);
    exp_cnt(t + 7, "par_ch0", 0, 4'd5);
    exp_cnt(t + 7, "par_ch1_sat", 1, 4'd15);
    exp_cnt(t + 7, "par_ch2", 2, 4'd9);
    exp_cnt(t + 7, "par_ch3", 3, 4'd10);
    exp_cnt(t + 7, "par_ch7", 7, 4'd6);
    step(1);
    start_req = '0;
    step(2);
    stop_req = 8'h55;
    step(1);
    stop_req = '0;
    step(4);

    // Only reset clears lock_lost; it also stops running channels without an ack.
    t = cyc;
    reset = 1'b1;
    exp_state(t + 1, "final_reset", 8'h00, 1'b1, 1'b0);
    exp_cnt(t + 1, "final_reset_ch1", 1, 4'd0);
    exp_cnt(t + 1, "final_reset_ch3", 3, 4'd0);
    step(1);
    reset = 1'b0;
    step(3);
    @(negedge clock);
    #1;

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL %s: never checked (cycle %0d)", mon_e.name, mon_e.cyc);
    end
    while (ackq.size() > 0) begin
      mon_a = ackq.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missing_ack: got none want ack=%h at cycle %0d", mon_a.mask, mon_a.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
